// File: rtl/snn_decay_pkg.sv
// Shared types and constants for the potential decay scheduler.
// Holds FSM encoding, neuron model codes and FP32 decay factors.
package snn_decay_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODEL_LIF  = 2'b00,
    MODEL_ALT1 = 2'b01,
    MODEL_ALT2 = 2'b10,
    MODEL_ALT3 = 2'b11
  } model_e;

  localparam logic [31:0] FACTOR_1_000 = 32'h3F80_0000;
  localparam logic [31:0] FACTOR_0_500 = 32'h3F00_0000;
  localparam logic [31:0] FACTOR_0_750 = 32'h3F40_0000;
  localparam logic [31:0] FACTOR_0_875 = 32'h3F60_0000;

endpackage

// File: rtl/decay_factor_lut.sv
// Maps a decay-rate code to its FP32 multiplier constant.
// Codes above 3 saturate at the slowest-decay factor.
module decay_factor_lut
  import snn_decay_pkg::*;
(
  input  logic [3:0]  code,
  output logic [31:0] factor
);

  always_comb begin
    factor = FACTOR_0_875;
    case (code)
      4'd0:    factor = FACTOR_1_000;
      4'd1:    factor = FACTOR_0_500;
      4'd2:    factor = FACTOR_0_750;
      default: factor = FACTOR_0_875;
    endcase
  end

endmodule

// File: rtl/potential_decay_scheduler.sv
// Sweeps all neuron potentials through one shared external FP32
// multiplier, scaling each by a decay factor once per timestep.
module potential_decay_scheduler
  import snn_decay_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       model,
  input  logic [3:0]       decay_rate,
  input  logic             init_we,
  input  logic [IDX_W-1:0] init_idx,
  input  logic [31:0]      init_data,
  output logic             init_ready,
  output logic [31:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic             mul_valid,
  input  logic             mul_ready,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_res_valid,
  input  logic [31:0]      mul_res
);

  localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      factor_q, factor_d;
  logic [31:0]      res_q, res_d;
  logic [31:0]      pot_q [NUM_NEURONS];
  logic [31:0]      pot_d [NUM_NEURONS];
  logic [31:0]      lut_factor;
  logic             idx_ok;

  decay_factor_lut u_lut (
    .code   (decay_rate),
    .factor (lut_factor)
  );

  assign idx_ok  = {1'b0, init_idx} < NUM_W;
  assign rd_data = idx_ok ? pot_q[init_idx] : 32'h0;
  assign mul_a   = pot_q[idx_q];
  assign mul_b   = factor_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    factor_d   = factor_q;
    res_d      = res_q;
    pot_d      = pot_q;
    mul_valid  = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    init_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        init_ready = 1'b1;
        if (init_we && idx_ok) begin
          pot_d[init_idx] = init_data;
        end
        if (start) begin
          if (model == MODEL_LIF) begin
            factor_d = lut_factor;
            idx_d    = '0;
            state_d  = S_ISSUE;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        mul_valid = 1'b1;
        if (mul_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_res_valid) begin
          res_d   = mul_res;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        pot_d[idx_q] = res_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      factor_q <= FACTOR_1_000;
      res_q    <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      factor_q <= factor_d;
      res_q    <= res_d;
      pot_q    <= pot_d;
    end
  end

endmodule
